rvfi_commit_serializer: RTL and testbench
=========================================

// Module: rvfi_commit_serializer
// PURPOSE
//  Collects up to NRET retired-instruction trace records per cycle from the commit stage, stamps each
//  with a monotonically increasing retirement order, buffers them in a circular FIFO, and emits one
//  record per cycle on a valid/ready stream toward the trace/checker side. Commit is never stalled;
//  overflow drops whole bundles and is reported.
// PARAMETERS
//  NRET     2   commit ports per cycle (1..4)
//  DEPTH    16  FIFO entries; power of two, >= NRET
//  ORDER_W  64  width of retirement order counter
// PORTS
//  clk_i            in   1                     clock
//  rst_ni           in   1                     reset, asynchronous, active-low
//  flush_i          in   1                     synchronous FIFO clear
//  commit_valid_i   in   NRET                  per-port retire strobe; port 0 oldest
//  commit_rec_i     in   NRET x rvfi_rec_t     per-port record; its order field is ignored
//  out_valid_o      out  1                     head record available
//  out_ready_i      in   1                     consumer accepts head
//  out_rec_o        out  rvfi_rec_t            head record, order field filled
//  level_o          out  $clog2(DEPTH)+1       current occupancy
//  overflow_o       out  1                     sticky: at least one bundle dropped
//  drop_cnt_o       out  16                    saturating count of dropped records
//  clr_overflow_i   in   1                     clears overflow_o and drop_cnt_o
// BEHAVIOUR
//  Reset: out_valid_o=0, level_o=0, overflow_o=0, drop_cnt_o=0, order counter=0, pointers=0.
//  Per cycle: k = popcount(commit_valid_i). Valid ports are compacted in ascending port index.
//  - Each valid port is stamped with order = order_q + rank, where rank is the count of valid ports
//    below it. order_q += k every cycle, modulo 2^ORDER_W, whether the bundle is stored or dropped.
//  - pop = out_valid_o & out_ready_i. free = DEPTH - level + pop, so a same-cycle pop makes room.
//  - If k <= free, all k records are written at wr_ptr..wr_ptr+k-1, with pointer wrap modulo DEPTH.
//  - If k > free, the whole bundle is dropped (all-or-nothing, never a partial write).
//    overflow_o is set; drop_cnt_o += k, saturating at 16'hFFFF. Order still advances, so the
//    consumer sees an order gap.
//  Output: out_valid_o = (level != 0). out_rec_o = mem[rd_ptr]. Latency commit -> out_valid_o is
//    1 cycle. Head record and valid stay stable while out_valid_o & !out_ready_i.
//  level_next = level + (stored ? k : 0) - pop. A write and a pop in the same cycle are legal at full.
//  flush_i has priority over commit and pop:
//    pointers=0, level=0, out_valid_o=0 next cycle; same-cycle commits are discarded and not counted
//    as drops; order_q still advances by k; overflow_o and drop_cnt_o are unchanged.
//  clr_overflow_i: both cleared next cycle. If a drop occurs in the same cycle, the drop wins:
//    overflow_o=1 and drop_cnt_o=k.
//  Asynchronous reset mid-stream discards all contents immediately; no output glitch beyond the
//    reset values.
// STRUCTURE
//  rvfi_pkg gains typedef rvfi_rec_t, the single-retire packed record (valid, order, insn, trap,
//    cause, mode, rs1/rs2/rd addr+data, pc_rdata/wdata, mem addr/paddr/masks/data). The existing
//    NRET-packed struct is unchanged.
//  Sub-module rvfi_commit_compact: combinational prefix popcount giving rank[NRET] and k, shared by
//    order stamping and write-slot selection.
//  Storage is a flop array of DEPTH x rvfi_rec_t, with NRET write ports and one read port.
// TESTING
//  1 Reset, then port0 valid with pc=0x8000_0000 -> next cycle out_valid_o=1, order=0, level_o=1.
//  2 NRET=2, both ports valid for 3 cycles, out_ready_i=1 -> orders 0..5 emitted in order,
//    port0 before port1, one per cycle.
//  3 out_ready_i=0, fill to DEPTH=16, then a 2-wide bundle -> dropped; overflow_o=1, drop_cnt_o=2,
//    level_o=16; next stored record shows an order gap of 2.
//  4 Full FIFO with pop and a 1-wide commit in the same cycle -> stored, no overflow, level_o stays 16.
//  5 flush_i asserted with level_o=5 and a 2-wide commit -> level_o=0 and out_valid_o=0 next cycle;
//    next commit gets order = previous order_q + 2.
//  6 Preload order_q near 2^ORDER_W-1 (ORDER_W=8 build) -> orders 254, 255, 0 in sequence;
//    rd/wr pointer wrap across 3 FIFO passes holds data intact.

Source files
------------

// File: rtl/rvfi_pkg.sv
// Shared types for the RVFI commit serializer.
//   rvfi_rec_t : one retired instruction in RVFI form (single retire slot).
//   cnt_w()    : bits needed to hold a count of 0..n.
package rvfi_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned REC_ORDER_W = 64;

   typedef struct packed {
      logic                   valid;
      logic [REC_ORDER_W-1:0] order;
      logic [31:0]            insn;
      logic                   trap;
      logic [XLEN-1:0]        cause;
      logic [1:0]             mode;
      logic [4:0]             rs1_addr;
      logic [4:0]             rs2_addr;
      logic [4:0]             rd_addr;
      logic [XLEN-1:0]        rs1_rdata;
      logic [XLEN-1:0]        rs2_rdata;
      logic [XLEN-1:0]        rd_wdata;
      logic [XLEN-1:0]        pc_rdata;
      logic [XLEN-1:0]        pc_wdata;
      logic [XLEN-1:0]        mem_addr;
      logic [XLEN-1:0]        mem_paddr;
      logic [XLEN/8-1:0]      mem_rmask;
      logic [XLEN/8-1:0]      mem_wmask;
      logic [XLEN-1:0]        mem_rdata;
      logic [XLEN-1:0]        mem_wdata;
   } rvfi_rec_t;

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/rvfi_commit_compact.sv
// Prefix popcount over the commit strobes.
//   valid_i [NRET]        : per-port retire strobe, port 0 oldest
//   rank_o  [NRET] x CW   : number of valid ports strictly below each port
//   k_o     CW            : total number of valid ports
// rank_o is the offset of each port's record both in retirement order and in
// the FIFO write window, so the same value drives stamping and slot selection.
module rvfi_commit_compact
   import rvfi_pkg::*;
#(
   parameter int unsigned NRET = 2,
   parameter int unsigned CW   = cnt_w(NRET)
) (
   input  logic [NRET-1:0] valid_i,
   output logic [CW-1:0]   rank_o [NRET],
   output logic [CW-1:0]   k_o
);

   logic [CW-1:0] acc;

   always_comb begin
      acc = '0;
      for (int i = 0; i < int'(NRET); i++) begin
         rank_o[i] = acc;
         acc       = acc + CW'(valid_i[i]);
      end
      k_o = acc;
   end

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serializes up to NRET retired-instruction records per cycle into one record
// per cycle, stamping a running retirement order.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   flush_i               : synchronous FIFO clear (order counter keeps counting)
//   commit_valid_i/rec_i  : NRET commit ports, port 0 oldest; rec order ignored
//   out_valid_o/ready_i   : output stream; a record transfers on a cycle where
//                           both are high. While valid && !ready the head record
//                           and valid hold steady; valid never drops without a
//                           transfer except on flush or reset.
//   out_rec_o             : head record with order filled
//   level_o               : occupancy
//   overflow_o/drop_cnt_o : sticky drop flag and saturating dropped-record count
//   clr_overflow_i        : clears overflow_o and drop_cnt_o
// Commit is never back-pressured: a bundle that does not fit is dropped whole.
module rvfi_commit_serializer
   import rvfi_pkg::*;
#(
   parameter int unsigned NRET    = 2,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned ORDER_W = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       flush_i,
   input  logic [NRET-1:0]            commit_valid_i,
   input  rvfi_rec_t                  commit_rec_i [NRET],
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output rvfi_rec_t                  out_rec_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o,
   output logic [15:0]                drop_cnt_o,
   input  logic                       clr_overflow_i
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam int unsigned CW = cnt_w(NRET);

   rvfi_rec_t          mem_q [DEPTH];
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic [ORDER_W-1:0] order_q, order_d;
   logic               overflow_q, overflow_d;
   logic [15:0]        drop_cnt_q, drop_cnt_d;

   logic [CW-1:0]      rank [NRET];
   logic [CW-1:0]      k;
   logic               pop, store, drop;
   logic [LW:0]        free;
   logic [15:0]        drop_base;
   logic [16:0]        drop_sum;
   rvfi_rec_t          stamped [NRET];

   rvfi_commit_compact #(.NRET(NRET), .CW(CW)) u_compact (
      .valid_i (commit_valid_i),
      .rank_o  (rank),
      .k_o     (k)
   );

   always_comb begin
      pop   = out_valid_o & out_ready_i;
      // A same-cycle pop frees a slot, so a full FIFO still accepts a bundle.
      free  = (LW+1)'(DEPTH) - {1'b0, level_q} + (LW+1)'(pop);
      store = !flush_i && ((LW+1)'(k) <= free);
      drop  = !flush_i && ((LW+1)'(k) >  free);

      for (int i = 0; i < int'(NRET); i++) begin
         stamped[i]       = commit_rec_i[i];
         stamped[i].valid = 1'b1;
         stamped[i].order = REC_ORDER_W'(ORDER_W'(order_q + ORDER_W'(rank[i])));
      end

      order_d = order_q + ORDER_W'(k);

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (store) wr_ptr_d = wr_ptr_q + PW'(k);
         if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
         level_d = level_q + (store ? LW'(k) : '0) - LW'(pop);
      end

      // A drop in the same cycle as a clear wins: count restarts from k.
      drop_base  = clr_overflow_i ? 16'd0 : drop_cnt_q;
      drop_sum   = {1'b0, drop_base} + 17'(k);
      overflow_d = clr_overflow_i ? 1'b0 : overflow_q;
      drop_cnt_d = drop_base;
      if (drop) begin
         overflow_d = 1'b1;
         drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         order_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         order_q    <= order_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage carries no reset; level_q gates visibility of stale entries.
   always_ff @(posedge clk_i) begin
      if (store) begin
         for (int i = 0; i < int'(NRET); i++) begin
            if (commit_valid_i[i]) mem_q[wr_ptr_q + PW'(rank[i])] <= stamped[i];
         end
      end
   end

   assign out_valid_o = (level_q != '0);
   assign out_rec_o   = mem_q[rd_ptr_q];
   assign level_o     = level_q;
   assign overflow_o  = overflow_q;
   assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
module tb_rvfi_commit_serializer;
  import rvfi_pkg::*;

  localparam int unsigned NRET  = 2;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned OW    = 8;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [NRET-1:0] cvalid;
  rvfi_rec_t       rec_in [NRET];
  logic            out_valid;
  logic            out_ready;
  rvfi_rec_t       out_rec;
  logic [4:0]      level;
  logic            overflow;
  logic [15:0]     drop_cnt;
  logic            clr_ovf;

  int checks = 0;
  int errors = 0;

  logic [39:0] exp_q[$];

  rvfi_commit_serializer #(.NRET(NRET), .DEPTH(DEPTH), .ORDER_W(OW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .commit_valid_i (cvalid),
    .commit_rec_i   (rec_in),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_rec_o      (out_rec),
    .level_o        (level),
    .overflow_o     (overflow),
    .drop_cnt_o     (drop_cnt),
    .clr_overflow_i (clr_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rvfi_rec_t mk_rec(input logic [31:0] insn, input logic [31:0] pc);
    rvfi_rec_t r;
    r          = '0;
    r.insn     = insn;
    r.pc_rdata = pc;
    r.pc_wdata = pc + 32'd4;
    r.order    = 64'hDEAD_BEEF;  // must be overwritten by the stamp
    return r;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    cvalid    = '0;
    clr_ovf   = 1'b0;
    out_ready = 1'b0;
    rec_in[0] = '0;
    rec_in[1] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drive2(input logic [1:0] v, input logic [31:0] tag);
    cvalid    = v;
    rec_in[0] = mk_rec(tag, 32'h1000_0000 + tag);
    rec_in[1] = mk_rec(tag + 32'd1, 32'h1000_0000 + tag + 32'd1);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", out_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    cvalid    = 2'b01;
    rec_in[0] = mk_rec(32'h0000_0013, 32'h8000_0000);
    step();
    cvalid = '0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", out_valid); end
    checks++; if (out_rec.order !== 64'd0) begin errors++; $display("FAIL single_order got %0d want 0", out_rec.order); end
    checks++; if (out_rec.pc_rdata !== 32'h8000_0000) begin errors++; $display("FAIL single_pc got %h want 80000000", out_rec.pc_rdata); end
    checks++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_pop got v=%0b l=%0d want v=0 l=0", out_valid, level); end
  endtask

  task automatic test_back_to_back();
    int exp_o;
    int n;
    exp_o = 0;
    n     = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 3) drive2(2'b11, 32'(2 * c));
      else cvalid = '0;
      if (out_valid) begin
        checks++;
        if (out_rec.order !== 64'(exp_o) || out_rec.insn !== 32'(exp_o)) begin
          errors++;
          $display("FAIL b2b_order got order=%0d insn=%0d want %0d", out_rec.order, out_rec.insn, exp_o);
        end
        exp_o++;
        n++;
      end
      step();
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL b2b_count got %0d want 6", n); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] want;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive2(2'b11, 32'(2 * c));
      step();
    end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fill_level got %0d want 16", level); end
    // bundle with orders 16,17 does not fit
    drive2(2'b11, 32'd16);
    step();
    cvalid = '0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", overflow); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop got %0d want 2", drop_cnt); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
    // full + pop + 1-wide commit (order 18)
    out_ready = 1'b1;
    drive2(2'b01, 32'd18);
    step();
    out_ready = 1'b0;
    cvalid    = '0;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL fullpop_level got %0d want 16", level); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL fullpop_drop got %0d want 2", drop_cnt); end
    checks++; if (out_rec.order !== 64'd1) begin errors++; $display("FAIL fullpop_head got %0d want 1", out_rec.order); end
    // clear and drop together: drop wins, count restarts at k (orders 19,20 lost)
    clr_ovf = 1'b1;
    drive2(2'b11, 32'd19);
    step();
    cvalid = '0;
    checks++; if (overflow !== 1'b1 || drop_cnt !== 16'd2) begin errors++; $display("FAIL clr_drop got ovf=%0b cnt=%0d want 1/2", overflow, drop_cnt); end
    step();
    clr_ovf = 1'b0;
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL clr got ovf=%0b cnt=%0d want 0/0", overflow, drop_cnt); end
    // drain: orders 1..15 then 18 (gap of 2)
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      want = (i < 15) ? 8'(i + 1) : 8'd18;
      checks++;
      if (out_valid !== 1'b1 || out_rec.order !== 64'(want)) begin
        errors++;
        $display("FAIL drain_order got v=%0b order=%0d want %0d", out_valid, out_rec.order, want);
      end
      step();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL drain_empty got v=%0b l=%0d want 0/0", out_valid, level); end
  endtask

  task automatic test_flush();
    do_reset();
    drive2(2'b11, 32'd0); step();
    drive2(2'b11, 32'd2); step();
    drive2(2'b01, 32'd4); step();
    cvalid = '0;
    checks++; if (level !== 5'd5) begin errors++; $display("FAIL flush_pre_level got %0d want 5", level); end
    flush = 1'b1;
    drive2(2'b11, 32'd5);
    step();
    flush = 1'b0;
    cvalid = '0;
    checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got l=%0d v=%0b want 0/0", level, out_valid); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL flush_nodrop got ovf=%0b cnt=%0d want 0/0", overflow, drop_cnt); end
    // port 1 alone: rank 0, order 7
    drive2(2'b10, 32'd40);
    step();
    cvalid = '0;
    checks++; if (out_rec.order !== 64'd7) begin errors++; $display("FAIL flush_order got %0d want 7", out_rec.order); end
    checks++; if (out_rec.insn !== 32'd41 || level !== 5'd1) begin errors++; $display("FAIL flush_rec got insn=%0d l=%0d want 41/1", out_rec.insn, level); end
  endtask

  task automatic test_order_wrap();
    logic [39:0] e;
    logic [7:0]  ord;
    int          tag;
    int          guard;
    do_reset();
    // advance order to 254 without storing anything
    flush = 1'b1;
    cvalid = 2'b11;
    repeat (127) step();
    flush = 1'b0;
    cvalid = '0;
    ord = 8'd254;
    tag = 100;
    out_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wrap_extra got order=%0d want none", out_rec.order);
        end else begin
          e = exp_q.pop_front();
          if (out_rec.order !== 64'(e[39:32]) || out_rec.insn !== e[31:0]) begin
            errors++;
            $display("FAIL wrap_rec got order=%0d insn=%0d want %0d/%0d", out_rec.order, out_rec.insn, e[39:32], e[31:0]);
          end
        end
      end
      if (c % 2 == 0) begin
        drive2(2'b11, 32'(tag));
        exp_q.push_back({ord, 32'(tag)});
        exp_q.push_back({ord + 8'd1, 32'(tag + 1)});
        ord = ord + 8'd2;
        tag = tag + 2;
      end else begin
        cvalid = '0;
      end
      step();
    end
    cvalid = '0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (out_rec.order !== 64'(e[39:32]) || out_rec.insn !== e[31:0]) begin
          errors++;
          $display("FAIL wrap_tail got order=%0d insn=%0d want %0d/%0d", out_rec.order, out_rec.insn, e[39:32], e[31:0]);
        end
      end
      step();
      guard++;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout got %0d left want 0", exp_q.size()); end
    checks++; if (overflow !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_end got ovf=%0b v=%0b want 0/0", overflow, out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_order_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
